xor_decipher_rx: RTL
====================

# xor_decipher_rx

Receive-side counterpart of the XOR stream cipher. The block takes a serial ciphertext bit stream and hunts for a plaintext 16-bit sync word. On lock it reloads a Galois LFSR keystream from the configured seed and XOR-decrypts a fixed-length frame into bytes with a valid strobe. It shares the 64-bit `{taps, seed}` serial configuration chain format with the transmit-side cipher, so both ends can sit on one daisy chain.

## Interface
- `SYNC_WORD`, 16'hA5C3: plaintext preamble, sent MSB first and not encrypted.
- `FRAME_BYTES`, 16: encrypted payload bytes per frame, ≥1.
- `TAPS_DEFAULT`, 32'h00000060: reset value of the taps field.
- `SEED_DEFAULT`, 32'h00000055: reset value of the seed field.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `e` in 1: ciphertext/preamble bit.
- `e_valid` in 1: `e` is sampled on a rising edge only when this is high.
- `cfg_en` in 1: configuration shift enable.
- `cfg_i` in 1: configuration serial in.
- `cfg_o` out 1: configuration serial out, equal to `cfg_reg[0]`.
- `byte_o` out 8: decrypted byte.
- `byte_valid` out 1: one-cycle strobe, `byte_o` is valid.
- `frame_done` out 1: one-cycle strobe coincident with the last byte of a frame.
- `sync_lock` out 1: high while in DATA.

## Operation
- `cfg_reg[63:0]` = {taps, seed}.
  - Reset value is {TAPS_DEFAULT, SEED_DEFAULT}.
  - When `cfg_en`=1, each cycle: `cfg_reg` <= {`cfg_i`, `cfg_reg[63:1]`}.
  - `cfg_reg` is never modified by decryption.
- LFSR step (32-bit working state `s`): keystream bit `k` = `s[0]`; `s` <= (`s`>>1) ^ (`k` ? taps : 0).
- FSM has two states, HUNT and DATA.
- HUNT:
  - On each `e_valid`: `shreg[15:0]` <= {`shreg[14:0]`, `e`}.
  - If the new `shreg` equals `SYNC_WORD`, then: state <= DATA, `s` <= seed, bit counter <= 0, byte counter <= 0.
  - Overlapping matches are allowed; no bit is discarded.
- DATA:
  - On each `e_valid`: `p` = `e` ^ `s[0]`; step `s`; shift `p` MSB first into the byte register; increment the bit counter (0..7).
  - On the 8th bit: register the byte and pulse `byte_valid`; increment the byte counter.
  - If the byte counter reaches `FRAME_BYTES`: pulse `frame_done`, clear `shreg`, state <= HUNT.
- `cfg_en`=1 in any state:
  - Forces HUNT and clears `shreg` and both counters.
  - No `byte_valid` or `frame_done` is issued; `e` is ignored that cycle.
  - A partial byte is discarded.
- Counter widths: bit counter 3 bits; byte counter `$clog2(FRAME_BYTES+1)` bits.

## Timing
- Reset values: `byte_o`=0, `byte_valid`=0, `frame_done`=0, `sync_lock`=0, state HUNT, `shreg`=0, `cfg_o`=`SEED_DEFAULT[0]`=1.
- Sync detect:
  - `sync_lock` rises on the edge that samples the last sync bit.
  - The next `e_valid` bit is payload bit 7 of byte 0.
- Byte latency: `byte_valid` is high the cycle after the edge that samples the 8th bit; `byte_o` holds until the next strobe.
- `frame_done` is high in the same cycle as the last `byte_valid`; `sync_lock` falls in that same cycle.
- `e_valid` gaps of any length are allowed; state, LFSR and counters hold.
- `cfg_en` has priority over `e_valid`. `sync_lock` is low the cycle after `cfg_en` is sampled.
- `rst` mid-frame: everything returns to reset values immediately, including `cfg_reg`.

## Structure
- Package `xor_cipher_pkg`:
  - LFSR width constant (32);
  - default taps/seed constants;
  - FSM state enum {HUNT, DATA};
  - default sync word.
- One sub-module, `keystream_lfsr`: ports `clk`, `rst`, `load`, `step`, `taps[31:0]`, `seed[31:0]`, `k`.
  - `load` has priority over `step`.
  - Combinational `k` = `s[0]`.

## Test plan
- Reset: after `rst`, all outputs at reset values and `cfg_o`=1. Shifting 64 bits with `cfg_i`=0 makes `cfg_o` emit 0x00000060_00000055 LSB first.
- Default-key frame: send A5C3, then 16 ciphertext bytes from the model.
  - The first ciphertext byte is 0xA9 (keystream 1,0,1,0,1,0,0,1) and must decode to 0x00.
  - Plaintext 0x00..0x0F gives 16 `byte_valid` pulses carrying 0x00..0x0F, `frame_done` with byte 15, then `sync_lock`=0.
- `e_valid` gaps: same frame with random 0–5 idle cycles between bits -> identical byte sequence.
- Sync false match: stream A5C2, then A5C3 -> no lock on A5C2; lock exactly after the final bit of A5C3; payload decodes correctly.
- Reconfigure mid-frame: `cfg_en` during byte 5 -> `sync_lock` drops, no further strobes. After loading taps 0x80200003 and seed 0x12345678, a new frame encrypted with that key decodes correctly.
- `rst` asserted during byte 3 -> outputs return to 0 asynchronously; the next frame under default key decodes 0x00..0x0F.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_cipher_pkg
//  Description : Shared constants and types for the XOR stream cipher pair.
//                LFSR width, default key fields, default sync word and the
//                receive FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_cipher_pkg;

    localparam int          c_lfsr_w       = 32;
    localparam logic [31:0] c_taps_default = 32'h0000_0060;
    localparam logic [31:0] c_seed_default = 32'h0000_0055;
    localparam logic [15:0] c_sync_word    = 16'hA5C3;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/keystream_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : keystream_lfsr
//  Description : 32-bit Galois LFSR keystream generator.
//                clk, rst   : clock, asynchronous active-high reset
//                load       : reload state from seed (wins over step)
//                step       : advance one keystream bit
//                taps, seed : feedback polynomial and reload value
//                k          : current keystream bit (state LSB)
//  Revision    : 1.0 - initial release
// ============================================================================
module keystream_lfsr
    import xor_cipher_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [c_lfsr_w-1:0] taps,
    input  logic [c_lfsr_w-1:0] seed,
    output logic                k
);

    logic [c_lfsr_w-1:0] r_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= '0;
        end else if (load) begin
            r_s <= seed;
        end else if (step) begin
            // Galois form: the bit leaving the LSB folds the taps back in.
            r_s <= (r_s >> 1) ^ (r_s[0] ? taps : '0);
        end
    end

    assign k = r_s[0];

endmodule
`default_nettype wire

// File: rtl/xor_decipher_rx.sv
`default_nettype none
// ============================================================================
//  Module      : xor_decipher_rx
//  Description : Serial XOR stream decipher. Hunts for a plaintext sync word,
//                then decrypts FRAME_BYTES bytes with a Galois LFSR keystream
//                reloaded from the configured seed at every lock.
//                clk, rst    : clock, asynchronous active-high reset
//                e, e_valid  : serial ciphertext/preamble bit and qualifier
//                cfg_en      : shift the 64-bit {taps, seed} chain (aborts rx)
//                cfg_i/cfg_o : configuration chain serial in / out
//                byte_o      : last decrypted byte
//                byte_valid  : one-cycle strobe for byte_o
//                frame_done  : one-cycle strobe with the last byte of a frame
//                sync_lock   : high while decrypting a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_decipher_rx
    import xor_cipher_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD    = c_sync_word,
    parameter int          FRAME_BYTES  = 16,
    parameter logic [31:0] TAPS_DEFAULT = c_taps_default,
    parameter logic [31:0] SEED_DEFAULT = c_seed_default
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       e_valid,
    input  logic       cfg_en,
    input  logic       cfg_i,
    output logic       cfg_o,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       sync_lock
);

    localparam int                  c_bcnt_w = $clog2(FRAME_BYTES + 1);
    localparam logic [c_bcnt_w-1:0] c_last   = c_bcnt_w'(FRAME_BYTES);

    // Registered state
    logic [63:0]         r_cfg;
    state_t              r_state;
    logic [15:0]         r_shreg;
    logic [2:0]          r_bit_cnt;
    logic [c_bcnt_w-1:0] r_byte_cnt;
    logic [6:0]          r_byte_sr;     // the 8th bit goes straight to byte_o

    // Combinational next-state / control
    state_t              w_state_nxt;
    logic [15:0]         w_shreg_nxt;
    logic [2:0]          w_bit_cnt_nxt;
    logic [c_bcnt_w-1:0] w_byte_cnt_nxt;
    logic [6:0]          w_byte_sr_nxt;
    logic                w_load;
    logic                w_step;
    logic                w_emit;
    logic                w_last;
    logic                w_k;
    logic [15:0]         w_shreg_shift;
    logic [7:0]          w_byte_full;
    logic [c_bcnt_w-1:0] w_byte_cnt_inc;

    assign w_shreg_shift  = {r_shreg[14:0], e};
    assign w_byte_full    = {r_byte_sr, e ^ w_k};
    assign w_byte_cnt_inc = r_byte_cnt + c_bcnt_w'(1);

    keystream_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_step),
        .taps (r_cfg[63:32]),
        .seed (r_cfg[31:0]),
        .k    (w_k)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_byte_sr_nxt  = r_byte_sr;
        w_load         = 1'b0;
        w_step         = 1'b0;
        w_emit         = 1'b0;
        w_last         = 1'b0;

        if (cfg_en) begin
            // Reconfiguration aborts any frame; the current bit is ignored.
            w_state_nxt    = HUNT;
            w_shreg_nxt    = '0;
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = '0;
        end else if (e_valid) begin
            case (r_state)
                HUNT: begin
                    w_shreg_nxt = w_shreg_shift;
                    if (w_shreg_shift == SYNC_WORD) begin
                        w_state_nxt    = DATA;
                        w_load         = 1'b1;
                        w_bit_cnt_nxt  = '0;
                        w_byte_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    w_step        = 1'b1;
                    w_byte_sr_nxt = w_byte_full[6:0];
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_emit         = 1'b1;
                        w_byte_cnt_nxt = w_byte_cnt_inc;
                        if (w_byte_cnt_inc == c_last) begin
                            w_last      = 1'b1;
                            w_state_nxt = HUNT;
                            w_shreg_nxt = '0;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg      <= {TAPS_DEFAULT, SEED_DEFAULT};
            r_state    <= HUNT;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_byte_sr  <= '0;
            byte_o     <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (cfg_en) begin
                r_cfg <= {cfg_i, r_cfg[63:1]};
            end
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_byte_sr  <= w_byte_sr_nxt;
            byte_valid <= w_emit;
            frame_done <= w_last;
            if (w_emit) begin
                byte_o <= w_byte_full;
            end
        end
    end

    assign cfg_o     = r_cfg[0];
    assign sync_lock = (r_state == DATA);

endmodule
`default_nettype wire
